// File: rtl/aes_job_arbiter.sv
// aes_job_arbiter: shares one AES controller between NUM_CH AXI-stream job
// sources. A whole job (command + beat stream ending in tlast) is granted at a
// time, passed through unbuffered, and the controller's completion pulse is
// routed back to the owning channel.
// Optional feature: define AES_ARB_STRICT_PRIO_EN for fixed priority (lowest
// channel index wins) instead of round-robin.
module aes_job_arbiter #(
    parameter int NUM_CH     = 2,
    parameter int DATA_WIDTH = 128,
    parameter int CMD_WIDTH  = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH*CMD_WIDTH-1:0]  s_cmd,
    input  logic [NUM_CH*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_CH-1:0]            s_tvalid,
    input  logic [NUM_CH-1:0]            s_tlast,
    output logic [NUM_CH-1:0]            s_tready,
    output logic [DATA_WIDTH-1:0]        m_tdata,
    output logic                         m_tvalid,
    output logic                         m_tlast,
    input  logic                         m_tready,
    output logic [CMD_WIDTH-1:0]         aes_cmd,
    input  logic                         processing_done,
    output logic [NUM_CH-1:0]            ch_done,
    output logic [2:0]                   grant_id,
    output logic                         busy
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FWD       = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [2:0]              r_rr_ptr;
    logic [2:0]              r_grant_id;
    logic                    r_busy;
    logic [CMD_WIDTH-1:0]    r_aes_cmd;
    logic [NUM_CH-1:0]       r_ch_done;

    logic                    w_any_req;
    logic [2:0]              w_pick;
    logic [CMD_WIDTH-1:0]    w_pick_cmd;
    logic [DATA_WIDTH-1:0]   w_sel_data;
    logic                    w_sel_valid;
    logic                    w_sel_last;
    logic                    w_grant;
    logic                    w_job_end;
    logic [2:0]              w_next_ptr;

    // Pick the first requesting channel at or after the search start point.
    always_comb begin
        int idx;
        w_any_req = 1'b0;
        w_pick    = 3'd0;
        idx       = 0;
        for (int k = 0; k < NUM_CH; k++) begin
`ifdef AES_ARB_STRICT_PRIO_EN
            idx = k;
`else
            idx = int'(r_rr_ptr) + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
`endif
            for (int j = 0; j < NUM_CH; j++) begin
                if (!w_any_req && (j == idx) && s_tvalid[j]) begin
                    w_any_req = 1'b1;
                    w_pick    = 3'(j);
                end
            end
        end
    end

    // Command word of the channel about to be granted.
    always_comb begin
        w_pick_cmd = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (3'(j) == w_pick) begin
                w_pick_cmd = s_cmd[j*CMD_WIDTH +: CMD_WIDTH];
            end
        end
    end

    // Stream signals of the currently owning channel.
    always_comb begin
        w_sel_data  = '0;
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (3'(j) == r_grant_id) begin
                w_sel_data  = s_tdata[j*DATA_WIDTH +: DATA_WIDTH];
                w_sel_valid = s_tvalid[j];
                w_sel_last  = s_tlast[j];
            end
        end
    end

    // Pass-through only while forwarding; every handshake is closed otherwise.
    always_comb begin
        m_tdata  = w_sel_data;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        s_tready = '0;
        if (r_state == ST_FWD) begin
            m_tvalid = w_sel_valid;
            m_tlast  = w_sel_last;
            for (int j = 0; j < NUM_CH; j++) begin
                if (3'(j) == r_grant_id) begin
                    s_tready[j] = m_tready;
                end
            end
        end
    end

    assign w_grant    = (r_state == ST_IDLE) && w_any_req;
    assign w_job_end  = (r_state == ST_WAIT_DONE) && processing_done;
    assign w_next_ptr = (r_grant_id == 3'(NUM_CH - 1)) ? 3'd0 : (r_grant_id + 3'd1);

    // Next-state decode: a job ends on the tlast transfer, then waits for the controller.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_next_state = ST_FWD;
                end
            end
            ST_FWD: begin
                if (w_sel_valid && m_tready && w_sel_last) begin
                    w_next_state = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (processing_done) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Grant bookkeeping: owner, latched command, busy flag, completion routing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr   <= 3'd0;
            r_grant_id <= 3'd0;
            r_busy     <= 1'b0;
            r_aes_cmd  <= '0;
            r_ch_done  <= '0;
        end else begin
            r_ch_done <= '0;
            if (w_grant) begin
                r_grant_id <= w_pick;
                r_aes_cmd  <= w_pick_cmd;
                r_busy     <= 1'b1;
            end
            if (w_job_end) begin
                for (int j = 0; j < NUM_CH; j++) begin
                    if (3'(j) == r_grant_id) begin
                        r_ch_done[j] <= 1'b1;
                    end
                end
                r_busy <= 1'b0;
`ifdef AES_ARB_STRICT_PRIO_EN
                r_rr_ptr <= 3'd0;
`else
                r_rr_ptr <= w_next_ptr;
`endif
            end
        end
    end

    assign aes_cmd  = r_aes_cmd;
    assign ch_done  = r_ch_done;
    assign grant_id = r_grant_id;
    assign busy     = r_busy;

endmodule

// File: tb/tb_aes_job_arbiter.sv
// Testbench for aes_job_arbiter: directed scenarios plus randomized multi-channel
// traffic checked against a job-level reference model (round-robin or, with
// AES_ARB_STRICT_PRIO_EN, fixed priority).
module tb_aes_job_arbiter;
    localparam int NCH  = 3;
    localparam int DW   = 128;
    localparam int CW   = 32;
    localparam int MAXJ = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NCH*CW-1:0] s_cmd = '0;
    logic [NCH*DW-1:0] s_tdata = '0;
    logic [NCH-1:0]    s_tvalid = '0;
    logic [NCH-1:0]    s_tlast = '0;
    logic [NCH-1:0]    s_tready;
    logic [DW-1:0]     m_tdata;
    logic              m_tvalid;
    logic              m_tlast;
    logic              m_tready = 1'b0;
    logic [CW-1:0]     aes_cmd;
    logic              processing_done = 1'b0;
    logic [NCH-1:0]    ch_done;
    logic [2:0]        grant_id;
    logic              busy;

    aes_job_arbiter #(.NUM_CH(NCH), .DATA_WIDTH(DW), .CMD_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .s_cmd(s_cmd), .s_tdata(s_tdata),
        .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
        .m_tready(m_tready), .aes_cmd(aes_cmd), .processing_done(processing_done),
        .ch_done(ch_done), .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int mptr     = 0;

    // Job definitions shared by stimulus and model
    int          cfg_jobs[NCH];
    int          job_len[NCH][MAXJ];
    logic [CW-1:0] job_cmd[NCH][MAXJ];
    logic [31:0] salt = 32'h5A17_C3E1;
    int cfg_gap_pct, cfg_ready_mode, cfg_ready_pct, cfg_done_delay, cfg_early_done;

    // Observations from one traffic run
    int             obs_grant[$];
    logic [CW-1:0]  obs_cmd[$];
    logic [DW-1:0]  obs_data[$];
    logic           obs_last[$];
    logic [NCH-1:0] obs_req[$];
    logic [NCH-1:0] obs_done[$];
    int obs_bad_ready, obs_bad_valid, obs_bad_done, obs_unstable, obs_timeout, obs_early, obs_cmd_drift;

    function automatic logic [DW-1:0] beat_data(int ch, int j, int b);
        logic [31:0] w;
        w = salt ^ 32'(ch * 65536 + j * 256 + b);
        return {w, ~w, w + 32'd1, 32'(b)};
    endfunction

    function automatic int model_pick(logic [NCH-1:0] m, int ptr);
        int c;
        for (int k = 0; k < NCH; k++) begin
`ifdef AES_ARB_STRICT_PRIO_EN
            c = k;
`else
            c = (ptr + k) % NCH;
`endif
            if (m[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [NCH-1:0] onehot(int c);
        logic [NCH-1:0] v;
        v = '0;
        if (c >= 0 && c < NCH) v[c] = 1'b1;
        return v;
    endfunction

    task automatic clear_jobs();
        for (int c = 0; c < NCH; c++) begin
            cfg_jobs[c] = 0;
            for (int j = 0; j < MAXJ; j++) begin
                job_len[c][j] = 1;
                job_cmd[c][j] = $urandom;
            end
        end
        cfg_gap_pct = 0; cfg_ready_mode = 0; cfg_ready_pct = 100;
        cfg_done_delay = 0; cfg_early_done = 0;
    endtask

    // Drives channel sources, m_tready and processing_done; records what the DUT does.
    task automatic run_traffic(input int budget);
        int pj[NCH];
        int pb[NCH];
        int phase, owner, cnt, done_owner;
        bit done_prev, prev_busy, stall_pend, finished, has, all_done;
        logic [DW-1:0]  stall_data;
        logic [NCH-1:0] vmask, exp_done, exp_rdy;
        obs_grant.delete(); obs_cmd.delete(); obs_data.delete(); obs_last.delete();
        obs_req.delete(); obs_done.delete();
        obs_bad_ready = 0; obs_bad_valid = 0; obs_bad_done = 0; obs_unstable = 0;
        obs_timeout = 0; obs_early = 0; obs_cmd_drift = 0;
        for (int c = 0; c < NCH; c++) begin pj[c] = 0; pb[c] = 0; end
        phase = 0; owner = 0; cnt = 0; done_owner = 0;
        done_prev = 0; prev_busy = 0; stall_pend = 0; finished = 0; stall_data = '0;
        for (int cyc = 0; cyc < budget && !finished; cyc++) begin
            @(negedge clk);
            for (int c = 0; c < NCH; c++) begin
                has = pj[c] < cfg_jobs[c];
                vmask[c] = has && ($urandom_range(99) >= cfg_gap_pct);
                s_tvalid[c] = vmask[c];
                s_tdata[c*DW +: DW] = has ? beat_data(c, pj[c], pb[c]) : DW'($urandom);
                s_tlast[c] = has && (pb[c] == job_len[c][has ? pj[c] : 0] - 1);
                s_cmd[c*CW +: CW] = (has && pb[c] == 0) ? job_cmd[c][pj[c]] : CW'($urandom);
            end
            m_tready = (cfg_ready_mode == 1) ? (cyc % 2 == 0) : ($urandom_range(99) < cfg_ready_pct);
            exp_done = done_prev ? onehot(done_owner) : '0;
            done_prev = 0;
            processing_done = 1'b0;
            if (phase == 2) begin
                if (cnt == 0) begin
                    processing_done = 1'b1; done_prev = 1; done_owner = owner; phase = 3;
                end else cnt--;
            end else if (phase == 1 && cfg_early_done != 0) begin
                processing_done = 1'b1; obs_early++;
            end
            #1;
            if (ch_done != '0) obs_done.push_back(ch_done);
            if (ch_done !== exp_done) obs_bad_done++;
            if (busy && !prev_busy) begin
                obs_grant.push_back(int'(grant_id)); obs_cmd.push_back(aes_cmd);
                owner = int'(grant_id); phase = 1;
            end
            if (!busy) phase = 0;
            if (busy && obs_cmd.size() > 0 && aes_cmd !== obs_cmd[$]) obs_cmd_drift++;
            prev_busy = busy;
            exp_rdy = (phase == 1) ? onehot(owner) & {NCH{m_tready}} : '0;
            if (s_tready !== exp_rdy) obs_bad_ready++;
            if (phase == 1 && owner < NCH) begin
                if (m_tvalid !== vmask[owner] ||
                    (vmask[owner] && (m_tdata !== s_tdata[owner*DW +: DW] || m_tlast !== s_tlast[owner])))
                    obs_bad_valid++;
            end else if (m_tvalid !== 1'b0) obs_bad_valid++;
            if (stall_pend && m_tvalid && m_tdata !== stall_data) obs_unstable++;
            stall_pend = m_tvalid && !m_tready;
            stall_data = m_tdata;
            if (m_tvalid && m_tready) begin
                obs_data.push_back(m_tdata); obs_last.push_back(m_tlast);
                if (m_tlast && phase == 1) begin phase = 2; cnt = cfg_done_delay; end
            end
            for (int c = 0; c < NCH; c++) begin
                if (pj[c] < cfg_jobs[c] && s_tvalid[c] && s_tready[c]) begin
                    if (pb[c] == job_len[c][pj[c]] - 1) begin pj[c]++; pb[c] = 0; end
                    else pb[c]++;
                end
            end
            if (!busy && s_tvalid != '0) obs_req.push_back(s_tvalid);
            all_done = 1;
            for (int c = 0; c < NCH; c++) if (pj[c] < cfg_jobs[c]) all_done = 0;
            finished = all_done && phase == 0 && !busy && !done_prev;
        end
        if (!finished) obs_timeout = 1;
        @(negedge clk);
        s_tvalid = '0; s_tlast = '0; processing_done = 1'b0; m_tready = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        s_tvalid = '1; m_tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_checks++; if (grant_id !== 3'd0) begin n_fail++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
        n_checks++; if (aes_cmd !== '0) begin n_fail++; $display("FAIL reset_aes_cmd: got %0h expected 0", aes_cmd); end
        n_checks++; if (ch_done !== '0) begin n_fail++; $display("FAIL reset_ch_done: got %0b expected 0", ch_done); end
        n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_m_tvalid: got %0b expected 0", m_tvalid); end
        n_checks++; if (s_tready !== '0) begin n_fail++; $display("FAIL reset_s_tready: got %0b expected 0", s_tready); end
        s_tvalid = '0; m_tready = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_no_req_busy: got %0b expected 0", busy); end
        mptr = 0;
    endtask

    task automatic test_single_job();
        clear_jobs();
        cfg_jobs[0] = 1; job_len[0][0] = 4; job_cmd[0][0] = 32'h0000_0105; cfg_done_delay = 2;
        run_traffic(200);
        n_checks++; if (obs_timeout !== 0) begin n_fail++; $display("FAIL single_timeout: got %0d expected 0", obs_timeout); end
        n_checks++; if (obs_grant.size() !== 1 || obs_grant[0] !== 0) begin n_fail++; $display("FAIL single_grant: got %0d grants first %0d expected 1 grant of ch0", obs_grant.size(), obs_grant[0]); end
        n_checks++; if (obs_cmd[0] !== 32'h0000_0105) begin n_fail++; $display("FAIL single_aes_cmd: got %0h expected 105", obs_cmd[0]); end
        n_checks++; if (obs_data.size() !== 4) begin n_fail++; $display("FAIL single_beats: got %0d expected 4", obs_data.size()); end
        for (int b = 0; b < 4 && b < obs_data.size(); b++) begin
            n_checks++;
            if (obs_data[b] !== beat_data(0, 0, b) || obs_last[b] !== (b == 3)) begin
                n_fail++; $display("FAIL single_beat%0d: got %0h last %0b expected %0h last %0b", b, obs_data[b], obs_last[b], beat_data(0, 0, b), b == 3);
            end
        end
        n_checks++; if (obs_done.size() !== 1 || obs_done[0] !== 3'b001) begin n_fail++; $display("FAIL single_ch_done: got %0d pulses first %0b expected one 001", obs_done.size(), obs_done[0]); end
        n_checks++; if (obs_bad_done !== 0 || obs_bad_ready !== 0) begin n_fail++; $display("FAIL single_timing: got done_err %0d ready_err %0d expected 0 0", obs_bad_done, obs_bad_ready); end
        mptr = 1;
    endtask

    task automatic test_reset_mid_fwd();
        int n, xfers;
        @(negedge clk);
        s_cmd = '0; s_cmd[CW-1:0] = 32'h0000_0207;
        s_tdata = '0; s_tdata[DW-1:0] = beat_data(0, 7, 0);
        s_tlast = '0; s_tvalid = 3'b001; m_tready = 1'b1; processing_done = 1'b0;
        n = 0;
        while (!busy && n < 10) begin @(negedge clk); n++; end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_grant: got busy %0b expected 1", busy); end
        xfers = 0;
        for (int b = 0; b < 2; b++) begin
            #1; if (m_tvalid && m_tready && s_tready[0]) xfers++;
            @(negedge clk); s_tdata[DW-1:0] = beat_data(0, 7, b + 1);
        end
        n_checks++; if (xfers !== 2 || aes_cmd !== 32'h0000_0207) begin n_fail++; $display("FAIL midrst_pre: got %0d xfers cmd %0h expected 2 xfers cmd 207", xfers, aes_cmd); end
        #2 reset = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || grant_id !== 3'd0 || aes_cmd !== '0) begin n_fail++; $display("FAIL midrst_regs: got busy %0b grant %0d cmd %0h expected 0 0 0", busy, grant_id, aes_cmd); end
        n_checks++; if (m_tvalid !== 1'b0 || s_tready !== '0 || ch_done !== '0) begin n_fail++; $display("FAIL midrst_stream: got m_tvalid %0b s_tready %0b ch_done %0b expected 0 0 0", m_tvalid, s_tready, ch_done); end
        @(negedge clk);
        s_cmd[CW +: CW] = 32'h0000_0333; s_cmd[2*CW +: CW] = 32'h0000_0444;
        s_tvalid = 3'b111; reset = 1'b1;
        n = 0;
        while (!busy && n < 10) begin @(negedge clk); n++; end
        #1;
        n_checks++; if (busy !== 1'b1 || grant_id !== 3'd0 || aes_cmd !== 32'h0000_0207) begin n_fail++; $display("FAIL midrst_regrant: got busy %0b grant %0d cmd %0h expected 1 0 207", busy, grant_id, aes_cmd); end
        reset = 1'b0; s_tvalid = '0; m_tready = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        mptr = 0;
    endtask

    task automatic test_round_robin();
        int exp_order[6];
`ifdef AES_ARB_STRICT_PRIO_EN
        exp_order = '{0, 0, 0, 1, 1, 1};
`else
        exp_order = '{0, 1, 0, 1, 0, 1};
`endif
        clear_jobs();
        cfg_jobs[0] = 3; cfg_jobs[1] = 3; cfg_done_delay = 1;
        for (int c = 0; c < 2; c++) for (int j = 0; j < 3; j++) job_len[c][j] = $urandom_range(1, 4);
        run_traffic(500);
        n_checks++; if (obs_timeout !== 0 || obs_grant.size() !== 6) begin n_fail++; $display("FAIL rr_count: got %0d grants timeout %0d expected 6 grants", obs_grant.size(), obs_timeout); end
        for (int k = 0; k < 6 && k < obs_grant.size(); k++) begin
            n_checks++; if (obs_grant[k] !== exp_order[k]) begin n_fail++; $display("FAIL rr_order%0d: got ch%0d expected ch%0d", k, obs_grant[k], exp_order[k]); end
        end
        n_checks++; if (obs_bad_ready !== 0 || obs_bad_valid !== 0) begin n_fail++; $display("FAIL rr_isolation: got ready_err %0d valid_err %0d expected 0 0", obs_bad_ready, obs_bad_valid); end
        mptr = (obs_grant.size() > 0) ? (obs_grant[$] + 1) % NCH : mptr;
    endtask

    task automatic test_stall();
        clear_jobs();
        cfg_jobs[2] = 1; job_len[2][0] = 3; cfg_ready_mode = 1; cfg_done_delay = 1;
        run_traffic(200);
        n_checks++; if (obs_timeout !== 0 || obs_data.size() !== 3) begin n_fail++; $display("FAIL stall_xfers: got %0d timeout %0d expected 3", obs_data.size(), obs_timeout); end
        n_checks++; if (obs_unstable !== 0) begin n_fail++; $display("FAIL stall_stable: got %0d changes expected 0", obs_unstable); end
        n_checks++; if (obs_bad_ready !== 0 || obs_bad_valid !== 0) begin n_fail++; $display("FAIL stall_wait_state: got ready_err %0d valid_err %0d expected 0 0", obs_bad_ready, obs_bad_valid); end
        n_checks++; if (obs_done.size() !== 1 || obs_done[0] !== 3'b100) begin n_fail++; $display("FAIL stall_ch_done: got %0d pulses first %0b expected one 100", obs_done.size(), obs_done[0]); end
        mptr = 0;
    endtask

    task automatic test_done_during_fwd();
        clear_jobs();
        cfg_jobs[1] = 1; job_len[1][0] = 4; cfg_ready_pct = 50; cfg_early_done = 1; cfg_done_delay = 3;
        run_traffic(300);
        n_checks++; if (obs_timeout !== 0 || obs_early == 0) begin n_fail++; $display("FAIL early_setup: got timeout %0d early %0d expected 0 and >0", obs_timeout, obs_early); end
        n_checks++; if (obs_data.size() !== 4) begin n_fail++; $display("FAIL early_beats: got %0d expected 4", obs_data.size()); end
        n_checks++; if (obs_done.size() !== 1 || obs_done[0] !== 3'b010) begin n_fail++; $display("FAIL early_ch_done: got %0d pulses first %0b expected one 010", obs_done.size(), obs_done[0]); end
        n_checks++; if (obs_bad_done !== 0 || obs_bad_ready !== 0) begin n_fail++; $display("FAIL early_timing: got done_err %0d ready_err %0d expected 0 0", obs_bad_done, obs_bad_ready); end
        mptr = 2;
    endtask

    task automatic test_random_traffic();
        int used[NCH];
        int g, eg, bi, j;
        for (int r = 0; r < 4; r++) begin
            clear_jobs();
            for (int c = 0; c < NCH; c++) begin
                cfg_jobs[c] = $urandom_range(0, 4);
                for (int k = 0; k < MAXJ; k++) job_len[c][k] = $urandom_range(1, 5);
                used[c] = 0;
            end
            if (r == 3) begin cfg_jobs[0] = 0; cfg_jobs[1] = 4; cfg_jobs[2] = 0; end
            cfg_gap_pct = 30; cfg_ready_pct = 70;
            cfg_done_delay = $urandom_range(0, 3); cfg_early_done = r % 2;
            run_traffic(4000);
            n_checks++; if (obs_timeout !== 0 || obs_req.size() !== obs_grant.size()) begin n_fail++; $display("FAIL rand%0d_progress: got timeout %0d reqs %0d grants %0d expected 0 equal", r, obs_timeout, obs_req.size(), obs_grant.size()); end
            n_checks++; if (obs_bad_ready + obs_bad_valid + obs_bad_done + obs_cmd_drift !== 0) begin n_fail++; $display("FAIL rand%0d_protocol: got ready %0d valid %0d done %0d cmd %0d expected all 0", r, obs_bad_ready, obs_bad_valid, obs_bad_done, obs_cmd_drift); end
            bi = 0;
            for (int k = 0; k < obs_grant.size() && k < obs_req.size(); k++) begin
                g = obs_grant[k];
                eg = model_pick(obs_req[k], mptr);
                n_checks++; if (g !== eg) begin n_fail++; $display("FAIL rand%0d_grant%0d: got ch%0d expected ch%0d", r, k, g, eg); end
                if (eg < 0) break;
                j = used[eg];
                used[eg]++;
                if (j >= cfg_jobs[eg]) break;
                n_checks++; if (obs_cmd[k] !== job_cmd[eg][j]) begin n_fail++; $display("FAIL rand%0d_cmd%0d: got %0h expected %0h", r, k, obs_cmd[k], job_cmd[eg][j]); end
                for (int b = 0; b < job_len[eg][j]; b++) begin
                    n_checks++;
                    if (bi >= obs_data.size() || obs_data[bi] !== beat_data(eg, j, b) || obs_last[bi] !== (b == job_len[eg][j] - 1)) begin
                        n_fail++; $display("FAIL rand%0d_beat%0d: got %0h expected %0h", r, bi, (bi < obs_data.size()) ? obs_data[bi] : '0, beat_data(eg, j, b));
                    end
                    bi++;
                end
                n_checks++; if (k >= obs_done.size() || obs_done[k] !== onehot(eg)) begin n_fail++; $display("FAIL rand%0d_done%0d: got %0b expected %0b", r, k, (k < obs_done.size()) ? obs_done[k] : '0, onehot(eg)); end
                mptr = (eg + 1) % NCH;
            end
            n_checks++; if (bi !== obs_data.size()) begin n_fail++; $display("FAIL rand%0d_extra_beats: got %0d expected %0d", r, obs_data.size(), bi); end
        end
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_reset_mid_fwd();
        test_round_robin();
        test_stall();
        test_done_during_fwd();
        test_random_traffic();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
